gpio_regfile: RTL and testbench

GPIO_REGFILE -- requirements
Module: gpio_regfile

---
 rtl/gpio_pkg.sv | 37 +++
 rtl/gpio_sync.sv | 32 +++
 rtl/gpio_regfile.sv | 111 +++++++++++
 tb/tb_gpio_regfile.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO register file: register offsets, index enum, default ID.
// Address decode helpers work on the word index (address bits [7:2]).
package gpio_pkg;

    localparam logic [7:0] ADDR_DATA_OUT = 8'h00;
    localparam logic [7:0] ADDR_DIR      = 8'h04;
    localparam logic [7:0] ADDR_DATA_IN  = 8'h08;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h0C;
    localparam logic [7:0] ADDR_IRQ_STAT = 8'h10;
    localparam logic [7:0] ADDR_IRQ_POL  = 8'h14;
    localparam logic [7:0] ADDR_IRQ_ANY  = 8'h18;
    localparam logic [7:0] ADDR_ID       = 8'h1C;

    localparam logic [31:0] ID_DEFAULT = 32'h4750_494F;
    localparam int unsigned NUM_REGS   = 8;

    typedef enum logic [5:0] {
        RegDataOut = 6'd0,
        RegDir     = 6'd1,
        RegDataIn  = 6'd2,
        RegIrqEn   = 6'd3,
        RegIrqStat = 6'd4,
        RegIrqPol  = 6'd5,
        RegIrqAny  = 6'd6,
        RegId      = 6'd7
    } reg_idx_e;

    function automatic logic idx_mapped(logic [5:0] idx);
        return idx < 6'(NUM_REGS);
    endfunction

    // DATA_IN and ID are read-only, so writes to them are access errors.
    function automatic logic idx_writable(logic [5:0] idx);
        return idx_mapped(idx) && (idx != RegDataIn) && (idx != RegId);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop pad synchronizer plus a history flop; emits the synchronized pad value
// and per-bit rising/falling edge strobes.
module gpio_sync (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_gpio,
    output logic [31:0] o_data_in,
    output logic [31:0] o_rise,
    output logic [31:0] o_fall
);

    logic [31:0] r_s1;
    logic [31:0] r_s2;
    logic [31:0] r_s3;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            r_s1 <= i_gpio;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_data_in = r_s2;
    assign o_rise    = r_s2 & ~r_s3;
    assign o_fall    = ~r_s2 & r_s3;

endmodule

// File: rtl/gpio_regfile.sv
// GPIO register file: output/direction registers, synchronized input sampling and
// edge-triggered interrupt status with W1C clear, behind a simple strobe bus.
module gpio_regfile
    import gpio_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = ID_DEFAULT,
    parameter logic [31:0] OUT_RST  = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic [7:0]  iPWADR,
    input  logic [31:0] iPWDAT,
    input  logic        iPWRTE,
    input  logic [7:0]  iPRADR,
    output logic [31:0] oPRDAT,
    output logic        oPERR,
    input  logic [31:0] iGPIO_I,
    output logic [31:0] oGPIO_O,
    output logic [31:0] oGPIO_OE,
    output logic        oIRQ
);

    logic [5:0]  w_wr_idx;
    logic [5:0]  w_rd_idx;
    logic        w_wr_en;
    logic [31:0] w_data_in;
    logic [31:0] w_rise;
    logic [31:0] w_fall;
    logic [31:0] w_hit;
    logic [31:0] w_w1c;
    logic [31:0] w_rd_data;
    logic [3:0]  w_unused_addr_lsb;

    logic [31:0] r_data_out;
    logic [31:0] r_dir;
    logic [31:0] r_irq_en;
    logic [31:0] r_irq_stat;
    logic [31:0] r_irq_pol;
    logic [31:0] r_irq_any;

    assign w_wr_idx          = iPWADR[7:2];
    assign w_rd_idx          = iPRADR[7:2];
    assign w_unused_addr_lsb = {iPWADR[1:0], iPRADR[1:0]};

    assign w_wr_en = iPWRTE & idx_writable(w_wr_idx);
    assign oPERR   = iPWRTE ? ~idx_writable(w_wr_idx) : ~idx_mapped(w_rd_idx);

    gpio_sync u_sync (
        .i_clk     (iCLK),
        .i_rst     (iRST),
        .i_gpio    (iGPIO_I),
        .o_data_in (w_data_in),
        .o_rise    (w_rise),
        .o_fall    (w_fall)
    );

    // ANY selects both edges; otherwise POL picks rising (1) or falling (0).
    assign w_hit = (r_irq_any & (w_rise | w_fall))
                 | (~r_irq_any & ((r_irq_pol & w_rise) | (~r_irq_pol & w_fall)));

    assign w_w1c = (w_wr_en && (w_wr_idx == RegIrqStat)) ? iPWDAT : '0;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_data_out <= OUT_RST;
            r_dir      <= '0;
            r_irq_en   <= '0;
            r_irq_pol  <= '0;
            r_irq_any  <= '0;
        end else if (w_wr_en) begin
            case (w_wr_idx)
                RegDataOut: r_data_out <= iPWDAT;
                RegDir:     r_dir      <= iPWDAT;
                RegIrqEn:   r_irq_en   <= iPWDAT;
                RegIrqPol:  r_irq_pol  <= iPWDAT;
                RegIrqAny:  r_irq_any  <= iPWDAT;
                default:    ;
            endcase
        end
    end

    // A new hit on the same bit wins over a simultaneous W1C.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_irq_stat <= '0;
        end else begin
            r_irq_stat <= (r_irq_stat & ~w_w1c) | w_hit;
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_rd_idx)
            RegDataOut: w_rd_data = r_data_out;
            RegDir:     w_rd_data = r_dir;
            RegDataIn:  w_rd_data = w_data_in;
            RegIrqEn:   w_rd_data = r_irq_en;
            RegIrqStat: w_rd_data = r_irq_stat;
            RegIrqPol:  w_rd_data = r_irq_pol;
            RegIrqAny:  w_rd_data = r_irq_any;
            RegId:      w_rd_data = ID_VALUE;
            default:    w_rd_data = '0;
        endcase
    end

    assign oPRDAT   = w_rd_data;
    assign oGPIO_O  = r_data_out;
    assign oGPIO_OE = r_dir;
    assign oIRQ     = |(r_irq_stat & r_irq_en);

endmodule

// File: tb/tb_gpio_regfile.sv
// Scoreboard bench for gpio_regfile: stimulus pushes model expectations into a queue,
// a negedge monitor pops and compares against the DUT outputs.
module tb_gpio_regfile;

    localparam logic [31:0] P_OUT_RST = 32'h1234_00C3;
    localparam logic [31:0] P_ID      = 32'h4750_494F;

    localparam logic [7:0] A_DOUT = 8'h00;
    localparam logic [7:0] A_DIR  = 8'h04;
    localparam logic [7:0] A_DIN  = 8'h08;
    localparam logic [7:0] A_EN   = 8'h0C;
    localparam logic [7:0] A_STAT = 8'h10;
    localparam logic [7:0] A_POL  = 8'h14;
    localparam logic [7:0] A_ANY  = 8'h18;
    localparam logic [7:0] A_ID   = 8'h1C;

    logic        iCLK;
    logic        iRST;
    logic [7:0]  iPWADR;
    logic [31:0] iPWDAT;
    logic        iPWRTE;
    logic [7:0]  iPRADR;
    logic [31:0] oPRDAT;
    logic        oPERR;
    logic [31:0] iGPIO_I;
    logic [31:0] oGPIO_O;
    logic [31:0] oGPIO_OE;
    logic        oIRQ;

    gpio_regfile #(
        .ID_VALUE (P_ID),
        .OUT_RST  (P_OUT_RST)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iPWADR   (iPWADR),
        .iPWDAT   (iPWDAT),
        .iPWRTE   (iPWRTE),
        .iPRADR   (iPRADR),
        .oPRDAT   (oPRDAT),
        .oPERR    (oPERR),
        .iGPIO_I  (iGPIO_I),
        .oGPIO_O  (oGPIO_O),
        .oGPIO_OE (oGPIO_OE),
        .oIRQ     (oIRQ)
    );

    always #5 iCLK = ~iCLK;

    // Reference model: plain register values plus a delay line of pad samples.
    logic [31:0] m_dout, m_dir, m_en, m_stat, m_pol, m_any;
    logic [31:0] m_hist [4];  // m_hist[0] = pad sampled at the latest edge
    logic [31:0] r_pad;

    typedef struct {
        logic [7:0]  ra;
        logic [31:0] prdat;
        logic        perr;
        logic [31:0] gout;
        logic [31:0] goe;
        logic        irq;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_mis = 0;

    function automatic logic wr_ok(input logic [7:0] a);
        int idx;
        idx = int'(a) / 4;
        return (idx < 8) && (idx != 2) && (idx != 7);
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (int'(a) / 4)
            0:       return m_dout;
            1:       return m_dir;
            2:       return m_hist[1];
            3:       return m_en;
            4:       return m_stat;
            5:       return m_pol;
            6:       return m_any;
            7:       return P_ID;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic m_perr(input logic wr, input logic [7:0] wa, input logic [7:0] ra);
        if (wr) return !wr_ok(wa);
        return ra >= 8'h20;
    endfunction

    always @(posedge iCLK or posedge iRST) begin : model
        logic [31:0] hit;
        logic [31:0] clr;
        if (iRST) begin
            m_dout = P_OUT_RST;
            m_dir  = '0;
            m_en   = '0;
            m_stat = '0;
            m_pol  = '0;
            m_any  = '0;
            for (int i = 0; i < 4; i++) m_hist[i] = '0;
        end else begin
            for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = iGPIO_I;
            // Interrupt fires one edge after the synchronized value changes.
            hit = '0;
            for (int b = 0; b < 32; b++) begin
                if (m_hist[2][b] != m_hist[3][b]) begin
                    if (m_any[b] || (m_pol[b] == m_hist[2][b])) hit[b] = 1'b1;
                end
            end
            clr = '0;
            if (iPWRTE && wr_ok(iPWADR)) begin
                case (int'(iPWADR) / 4)
                    0: m_dout = iPWDAT;
                    1: m_dir  = iPWDAT;
                    3: m_en   = iPWDAT;
                    4: clr    = iPWDAT;
                    5: m_pol  = iPWDAT;
                    6: m_any  = iPWDAT;
                    default: ;
                endcase
            end
            m_stat = (m_stat & ~clr) | hit;
        end
    end

    task automatic chk(input string name, input logic [7:0] ra,
                       input logic [31:0] act, input logic [31:0] expv);
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s (rd addr %h): got %h expected %h at %0t", name, ra, act, expv,
                     $time);
        end
    endtask

    always @(negedge iCLK) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_vec++;
            chk("prdat", mon_e.ra, oPRDAT, mon_e.prdat);
            chk("perr", mon_e.ra, {31'b0, oPERR}, {31'b0, mon_e.perr});
            chk("gpio_o", mon_e.ra, oGPIO_O, mon_e.gout);
            chk("gpio_oe", mon_e.ra, oGPIO_OE, mon_e.goe);
            chk("irq", mon_e.ra, {31'b0, oIRQ}, {31'b0, mon_e.irq});
        end
    end

    task automatic step(input logic wr, input logic [7:0] wa, input logic [31:0] wd,
                        input logic [7:0] ra);
        exp_t e;
        @(posedge iCLK);
        #2;
        iPWRTE  = wr;
        iPWADR  = wa;
        iPWDAT  = wd;
        iPRADR  = ra;
        iGPIO_I = r_pad;
        e.ra    = ra;
        e.prdat = m_read(ra);
        e.perr  = m_perr(wr, wa, ra);
        e.gout  = m_dout;
        e.goe   = m_dir;
        e.irq   = |(m_stat & m_en);
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        step(1'b1, a, d, A_STAT);
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b0, 8'h00, 32'h0, a);
    endtask

    function automatic logic [7:0] rand_addr();
        logic [7:0] a;
        if ($urandom_range(0, 4) == 0) a = 8'($urandom);
        else a = {3'b000, 3'($urandom), 2'($urandom)};
        return a;
    endfunction

    initial begin
        iCLK    = 1'b0;
        iRST    = 1'b0;
        iPWADR  = '0;
        iPWDAT  = '0;
        iPWRTE  = 1'b0;
        iPRADR  = '0;
        iGPIO_I = '0;
        r_pad   = '0;
        #1 iRST = 1'b1;
        repeat (3) @(posedge iCLK);
        #2 iRST = 1'b0;

        // Reset values across the whole map, including unmapped reads.
        for (int a = 0; a < 8'h20; a += 4) rd(8'(a));
        rd(8'h20);
        rd(8'hFF);

        // Direction and output registers reach the pins the following cycle.
        wr(A_DIR, 32'h0000_00FF);
        wr(A_DOUT, 32'h0000_00A5);
        rd(A_DOUT);
        rd(A_DIR);

        // Rising edge on bit 3 with interrupt enabled.
        wr(A_EN, 32'h0000_0008);
        wr(A_POL, 32'h0000_0008);
        r_pad[3] = 1'b1;
        repeat (4) rd(A_DIN);
        rd(A_STAT);

        // W1C colliding with a fresh hit, then a clean W1C.
        r_pad[3] = 1'b0;
        repeat (3) rd(A_STAT);
        r_pad[3] = 1'b1;
        rd(A_DIN);
        rd(A_DIN);
        wr(A_STAT, 32'h0000_0008);
        rd(A_STAT);
        wr(A_STAT, 32'h0000_0008);
        rd(A_STAT);

        // Error accesses change nothing; unmapped read returns zero.
        wr(A_DIN, 32'hFFFF_FFFF);
        wr(A_ID, 32'hFFFF_FFFF);
        wr(8'h40, 32'hFFFF_FFFF);
        rd(8'h24);
        rd(A_DIN);
        rd(A_ID);

        // Both-edge interrupt on bit 0 with a four-cycle pulse.
        wr(A_ANY, 32'h0000_0001);
        r_pad[0] = 1'b1;
        repeat (3) rd(A_STAT);
        wr(A_STAT, 32'h0000_0001);
        r_pad[0] = 1'b0;
        repeat (4) rd(A_STAT);

        // A write coincident with reset assertion is lost.
        @(posedge iCLK);
        #2;
        iPWRTE = 1'b1;
        iPWADR = A_DOUT;
        iPWDAT = 32'hDEAD_BEEF;
        iRST   = 1'b1;
        @(posedge iCLK);
        #2 iPWRTE = 1'b0;
        @(posedge iCLK);
        #2 iRST = 1'b0;
        rd(A_DOUT);
        repeat (3) rd(A_STAT);
        wr(A_STAT, 32'hFFFF_FFFF);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) r_pad = r_pad ^ $urandom;
            else if ($urandom_range(0, 2) == 0) r_pad[$urandom_range(0, 31)] ^= 1'b1;
            if ($urandom_range(0, 2) == 0) step(1'b1, rand_addr(), $urandom, rand_addr());
            else step(1'b0, rand_addr(), $urandom, rand_addr());
        end
        rd(A_STAT);

        repeat (2) @(posedge iCLK);
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
